gemm_sequencer: RTL and testbench

//   Controls one GEMM on the N x N systolic MAC array. Accepts an operand pair (A, B) over a

---
 rtl/gemm_sequencer.sv | 119 +++++++++++
 tb/tb_gemm_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/gemm_sequencer.sv
// Purpose: sequences one GEMM on an N x N systolic MAC array: latch A/B, clear, skewed feed, drain, snapshot C.
// Latency: accept at edge 0 -> mac_clear cycle 1, feed cycles 2..2N, drain 2N+1..3N, result_valid from cycle 3N+1.
// Backpressure: start_ready only in IDLE (no queueing); result held in DONE until result_ready.
module gemm_sequencer #(
    parameter int N         = 2,
    parameter int OP_WIDTH  = 8,
    parameter int ACC_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start_valid,
    output logic                       start_ready,
    input  logic [N*N*OP_WIDTH-1:0]    a_in,
    input  logic [N*N*OP_WIDTH-1:0]    b_in,
    output logic [N*OP_WIDTH-1:0]      new_a_column,
    output logic [N*OP_WIDTH-1:0]      new_b_row,
    output logic                       mac_clear,
    input  logic [N*N*ACC_WIDTH-1:0]   acc_in,
    output logic [N*N*ACC_WIDTH-1:0]   result,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic                       busy
);

    localparam int SW = (N > 1) ? $clog2(2*N) : 1;
    localparam logic [SW-1:0] LAST_FEED  = SW'(2*N-2);
    localparam logic [SW-1:0] LAST_DRAIN = SW'(N-1);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    state_t                   state;
    logic [SW-1:0]            step;
    logic [N*N*OP_WIDTH-1:0]  a_lat;
    logic [N*N*OP_WIDTH-1:0]  b_lat;
    logic [N*OP_WIDTH-1:0]    a_next;
    logic [N*OP_WIDTH-1:0]    b_next;
    int                       feed_s;

    // Buses are registered, so compute the lanes for the step about to be presented.
    always_comb begin
        a_next = '0;
        b_next = '0;
        feed_s = (state == FEED) ? int'(step) + 1 : 0;
        for (int r = 0; r < N; r++) begin
            if (feed_s >= r && feed_s < r + N) begin
                a_next[OP_WIDTH*r +: OP_WIDTH] = a_lat[OP_WIDTH*(r*N + feed_s - r) +: OP_WIDTH];
                b_next[OP_WIDTH*r +: OP_WIDTH] = b_lat[OP_WIDTH*((feed_s - r)*N + r) +: OP_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            step         <= '0;
            a_lat        <= '0;
            b_lat        <= '0;
            new_a_column <= '0;
            new_b_row    <= '0;
            mac_clear    <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            start_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_lat       <= a_in;
                        b_lat       <= b_in;
                        mac_clear   <= 1'b1;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        state       <= CLEAR;
                    end
                end
                CLEAR: begin
                    mac_clear    <= 1'b0;
                    step         <= '0;
                    new_a_column <= a_next;
                    new_b_row    <= b_next;
                    state        <= FEED;
                end
                FEED: begin
                    if (step == LAST_FEED) begin
                        new_a_column <= '0;
                        new_b_row    <= '0;
                        step         <= '0;
                        state        <= DRAIN;
                    end else begin
                        new_a_column <= a_next;
                        new_b_row    <= b_next;
                        step         <= step + SW'(1);
                    end
                end
                DRAIN: begin
                    if (step == LAST_DRAIN) begin
                        result       <= acc_in;
                        result_valid <= 1'b1;
                        step         <= '0;
                        state        <= DONE;
                    end else begin
                        step <= step + SW'(1);
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        start_ready  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gemm_sequencer.sv
// Directed bench for gemm_sequencer with a behavioural 2x2 systolic MAC array on acc_in.
module tb_gemm_sequencer;

    localparam int N = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_valid;
    logic         start_ready;
    logic [31:0]  a_in;
    logic [31:0]  b_in;
    logic [15:0]  new_a_column;
    logic [15:0]  new_b_row;
    logic         mac_clear;
    logic [127:0] acc_in;
    logic [127:0] result;
    logic         result_valid;
    logic         result_ready;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gemm_sequencer #(.N(N), .OP_WIDTH(8), .ACC_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .start_valid(start_valid), .start_ready(start_ready),
        .a_in(a_in), .b_in(b_in),
        .new_a_column(new_a_column), .new_b_row(new_b_row),
        .mac_clear(mac_clear), .acc_in(acc_in),
        .result(result), .result_valid(result_valid), .result_ready(result_ready),
        .busy(busy)
    );

    // Output-stationary array: A flows right, B flows down, each PE accumulates its inputs.
    logic [7:0]  ar [N][N];
    logic [7:0]  br [N][N];
    logic [7:0]  a_pe [N][N];
    logic [7:0]  b_pe [N][N];
    logic [31:0] acc [N][N];

    always_comb begin
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_pe[i][j] = (j == 0) ? new_a_column[8*i +: 8] : ar[i][j-1];
                b_pe[i][j] = (i == 0) ? new_b_row[8*j +: 8]    : br[i-1][j];
                acc_in[32*(i*N+j) +: 32] = acc[i][j];
            end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ar[i][j] <= (!reset) ? 8'd0 : a_pe[i][j];
                br[i][j] <= (!reset) ? 8'd0 : b_pe[i][j];
                if (!reset || mac_clear) acc[i][j] <= 32'd0;
                else acc[i][j] <= acc[i][j] + 32'(a_pe[i][j]) * 32'(b_pe[i][j]);
            end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0]  A_MAT  = {8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [31:0]  B_MAT  = {8'd8, 8'd7, 8'd6, 8'd5};
    localparam logic [31:0]  I_MAT  = {8'd1, 8'd0, 8'd0, 8'd1};
    localparam logic [127:0] C_AB   = {32'd50, 32'd43, 32'd22, 32'd19};
    localparam logic [127:0] C_IB   = {32'd8, 32'd7, 32'd6, 32'd5};

    logic [15:0] exp_a [3];
    logic [15:0] exp_b [3];
    int          lat;

    initial begin
        exp_a[0] = {8'd0, 8'd1}; exp_a[1] = {8'd3, 8'd2}; exp_a[2] = {8'd4, 8'd0};
        exp_b[0] = {8'd0, 8'd5}; exp_b[1] = {8'd6, 8'd7}; exp_b[2] = {8'd8, 8'd0};

        reset = 1'b0; start_valid = 1'b0; result_ready = 1'b0; a_in = '0; b_in = '0;
        tick(); tick();
        reset = 1'b1;
        chk("rst_start_ready", 128'(start_ready), 128'd1);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_result_valid", 128'(result_valid), 128'd0);
        chk("rst_mac_clear", 128'(mac_clear), 128'd0);
        chk("rst_a_bus", 128'(new_a_column), 128'd0);
        chk("rst_b_bus", 128'(new_b_row), 128'd0);
        chk("rst_result", result, 128'd0);

        // Job 1: accept, clear, skewed feed, drain, result.
        a_in = A_MAT; b_in = B_MAT; start_valid = 1'b1;
        tick();
        start_valid = 1'b0; a_in = '0; b_in = '0;
        chk("clr_mac_clear", 128'(mac_clear), 128'd1);
        chk("clr_start_ready", 128'(start_ready), 128'd0);
        chk("clr_busy", 128'(busy), 128'd1);
        for (int s = 0; s < 2*N-1; s++) begin
            tick();
            if (s == 0) begin
                // Unrelated job offered while busy must be ignored.
                start_valid = 1'b1; a_in = I_MAT; b_in = I_MAT;
            end
            chk($sformatf("feed_a_s%0d", s), 128'(new_a_column), 128'(exp_a[s]));
            chk($sformatf("feed_b_s%0d", s), 128'(new_b_row), 128'(exp_b[s]));
            chk($sformatf("feed_mac_clear_s%0d", s), 128'(mac_clear), 128'd0);
            chk($sformatf("feed_start_ready_s%0d", s), 128'(start_ready), 128'd0);
        end
        for (int d = 0; d < N; d++) begin
            tick();
            chk($sformatf("drain_a_%0d", d), 128'(new_a_column), 128'd0);
            chk($sformatf("drain_b_%0d", d), 128'(new_b_row), 128'd0);
            chk($sformatf("drain_result_valid_%0d", d), 128'(result_valid), 128'd0);
        end
        start_valid = 1'b0; a_in = '0; b_in = '0;
        tick();
        chk("lat7_result_valid", 128'(result_valid), 128'd1);
        chk("job1_result", result, C_AB);
        chk("done_start_ready", 128'(start_ready), 128'd0);

        // Backpressure in DONE.
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("hold_valid_%0d", k), 128'(result_valid), 128'd1);
            chk($sformatf("hold_result_%0d", k), result, C_AB);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("release_valid", 128'(result_valid), 128'd0);
        chk("release_busy", 128'(busy), 128'd0);
        chk("release_start_ready", 128'(start_ready), 128'd1);
        chk("release_result_kept", result, C_AB);

        // Job 2 aborted by reset at FEED step 1.
        a_in = A_MAT; b_in = B_MAT; start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        tick(); tick();
        chk("abort_at_step1_a", 128'(new_a_column), 128'(exp_a[1]));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_start_ready", 128'(start_ready), 128'd1);
        chk("abort_a_bus", 128'(new_a_column), 128'd0);
        chk("abort_b_bus", 128'(new_b_row), 128'd0);
        chk("abort_result_valid", 128'(result_valid), 128'd0);
        chk("abort_mac_clear", 128'(mac_clear), 128'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("abort_no_result_%0d", k), 128'(result_valid), 128'd0);
        end

        // Job 3: identity times B, bounded wait for result_valid.
        a_in = I_MAT; b_in = B_MAT; start_valid = 1'b1;
        tick();
        start_valid = 1'b0; a_in = '0; b_in = '0;
        lat = 1;
        while (!result_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("job3_valid_seen", 128'(result_valid), 128'd1);
        chk("job3_latency", 128'(lat), 128'd7);
        chk("job3_result", result, C_IB);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("job3_release", 128'(start_ready), 128'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
